// File: rtl/cdr_ctrl_pkg.sv
// Shared types and default constants for the CDR tap-step controller.
// Optional build macro: TAP_SATURATE_EN (see cdr_tap_step_controller).
package cdr_ctrl_pkg;

    localparam int N_TAPS     = 16;
    localparam int TAP_W      = 4;
    localparam int THRESH     = 8;
    localparam int ACC_W      = 5;
    localparam int SETTLE_CYC = 4;
    localparam int LOCK_CYC   = 256;

    // Loop sequencer states
    typedef enum logic {
        ACC    = 1'b0,
        SETTLE = 1'b1
    } state_e;

    // Step decision out of the vote accumulator
    typedef enum logic [1:0] {
        STEP_NONE = 2'b00,
        STEP_UP   = 2'b01,  // more delay (sl)
        STEP_DN   = 2'b10   // less delay (sr)
    } step_e;

endpackage

// File: rtl/cdr_vote_accumulator.sv
// Signed early/late vote integrator with symmetric threshold detect.
// The accumulator clears itself on the cycle a threshold is crossed.
module cdr_vote_accumulator
    import cdr_ctrl_pkg::*;
#(
    parameter int ACC_W  = 5,
    parameter int THRESH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             early,
    input  logic             late,
    output logic [ACC_W-1:0] acc,
    output step_e            step
);

    localparam logic signed [ACC_W:0] THR_P = (ACC_W+1)'(THRESH);
    localparam logic signed [ACC_W:0] THR_N = -THR_P;

    logic signed [ACC_W-1:0] acc_q, acc_d;
    logic signed [ACC_W:0]   vote_d;
    logic signed [ACC_W:0]   acc_n;

    // Extend by one bit so the sum cannot overflow before the compare
    always_comb begin
        vote_d = '0;
        if (early && !late) begin
            vote_d = (ACC_W+1)'(1);
        end else if (late && !early) begin
            vote_d = '1;
        end
        acc_n = $signed({acc_q[ACC_W-1], acc_q}) + vote_d;

        step  = STEP_NONE;
        acc_d = acc_q;
        if (en) begin
            if (acc_n >= THR_P) begin
                step = STEP_UP;
            end else if (acc_n <= THR_N) begin
                step = STEP_DN;
            end
            acc_d = (step != STEP_NONE) ? '0 : acc_n[ACC_W-1:0];
        end
    end

    // Accumulator register
    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

    assign acc = acc_q;

endmodule

// File: rtl/cdr_tap_step_controller.sv
// Loop filter and sequencer for the 16-tap shift-select delay line.
// Integrates PD votes, issues one-cycle sl/sr steps, waits out a settle
// interval, mirrors the tap index and reports lock.
// Build macro TAP_SATURATE_EN: taps saturate at the ends instead of wrapping,
// suppressed steps are flagged on tap_limit.
module cdr_tap_step_controller
    import cdr_ctrl_pkg::*;
#(
    parameter int N_TAPS     = cdr_ctrl_pkg::N_TAPS,
    parameter int TAP_W      = cdr_ctrl_pkg::TAP_W,
    parameter int THRESH     = cdr_ctrl_pkg::THRESH,
    parameter int ACC_W      = cdr_ctrl_pkg::ACC_W,
    parameter int SETTLE_CYC = cdr_ctrl_pkg::SETTLE_CYC,
    parameter int LOCK_CYC   = cdr_ctrl_pkg::LOCK_CYC
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             vote_valid,
    input  logic             early,
    input  logic             late,
    input  logic             freeze,
    output logic             sl,
    output logic             sr,
    output logic [TAP_W-1:0] tap_idx,
    output logic [ACC_W-1:0] acc_dbg,
    output logic             locked,
`ifdef TAP_SATURATE_EN
    output logic             tap_limit,
`endif
    output state_e           state_dbg
);

    localparam int SET_W = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
    localparam int LCK_W = $clog2(LOCK_CYC + 1);
    localparam logic [TAP_W-1:0] TAP_MAX  = TAP_W'(N_TAPS - 1);
    localparam logic [LCK_W-1:0] LOCK_VAL = LCK_W'(LOCK_CYC);

    state_e             state_q, state_d;
    logic [SET_W-1:0]   settle_q, settle_d;
    logic [LCK_W-1:0]   lock_q, lock_d;
    logic [TAP_W-1:0]   tap_q, tap_d;
    logic               sl_q, sl_d;
    logic               sr_q, sr_d;
    logic               locked_q, locked_d;
    logic               limit_q, limit_d;
    logic               acc_en;
    step_e              step_raw;
    step_e              step_ok;

    // Votes only count in ACC while the loop is not frozen
    assign acc_en = (state_q == ACC) && !freeze && vote_valid;

    cdr_vote_accumulator #(
        .ACC_W  (ACC_W),
        .THRESH (THRESH)
    ) u_acc (
        .clk   (clk),
        .rst   (rst),
        .en    (acc_en),
        .early (early),
        .late  (late),
        .acc   (acc_dbg),
        .step  (step_raw)
    );

    // Next-state: step issue, settle countdown, lock counting, tap mirror
    always_comb begin
        state_d  = state_q;
        settle_d = settle_q;
        lock_d   = lock_q;
        tap_d    = tap_q;
        sl_d     = 1'b0;
        sr_d     = 1'b0;
        limit_d  = 1'b0;
        step_ok  = step_raw;

`ifdef TAP_SATURATE_EN
        if ((step_raw == STEP_UP && tap_q == TAP_MAX) ||
            (step_raw == STEP_DN && tap_q == '0)) begin
            step_ok = STEP_NONE;
            limit_d = 1'b1;
        end
`endif

        case (state_q)
            ACC: begin
                if (!freeze) begin
                    if (lock_q != LOCK_VAL) begin
                        lock_d = lock_q + LCK_W'(1);
                    end
                    if (step_ok != STEP_NONE) begin
                        lock_d   = '0;
                        state_d  = SETTLE;
                        settle_d = SET_W'(SETTLE_CYC - 1);
                        if (step_ok == STEP_UP) begin
                            sl_d  = 1'b1;
                            tap_d = (tap_q == TAP_MAX) ? '0 : tap_q + TAP_W'(1);
                        end else begin
                            sr_d  = 1'b1;
                            tap_d = (tap_q == '0) ? TAP_MAX : tap_q - TAP_W'(1);
                        end
                    end
                end
            end
            SETTLE: begin
                if (settle_q == '0) begin
                    state_d = ACC;
                end else begin
                    settle_d = settle_q - SET_W'(1);
                end
            end
            default: state_d = ACC;
        endcase

        locked_d = (lock_d == LOCK_VAL);
    end

    // FSM and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ACC;
            settle_q <= '0;
            lock_q   <= '0;
            tap_q    <= '0;
            sl_q     <= 1'b0;
            sr_q     <= 1'b0;
            locked_q <= 1'b0;
            limit_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            settle_q <= settle_d;
            lock_q   <= lock_d;
            tap_q    <= tap_d;
            sl_q     <= sl_d;
            sr_q     <= sr_d;
            locked_q <= locked_d;
            limit_q  <= limit_d;
        end
    end

    assign sl        = sl_q;
    assign sr        = sr_q;
    assign tap_idx   = tap_q;
    assign locked    = locked_q;
    assign state_dbg = state_q;
`ifdef TAP_SATURATE_EN
    assign tap_limit = limit_q;
`else
    // Saturation flag has no output in the wrapping build
    logic unused_limit;
    assign unused_limit = limit_q;
`endif

endmodule

// File: tb/tb_cdr_tap_step_controller.sv
// Directed bench for cdr_tap_step_controller with a cycle-level reference
// model and literal spot checks.
module tb_cdr_tap_step_controller;
    import cdr_ctrl_pkg::*;

    localparam int TH   = 8;
    localparam int SCYC = 4;
    localparam int LCYC = 256;
    localparam int NT   = 16;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       vote_valid = 1'b0;
    logic       early = 1'b0;
    logic       late = 1'b0;
    logic       freeze = 1'b0;
    logic       sl, sr, locked;
    logic [3:0] tap_idx;
    logic [4:0] acc_dbg;
    state_e     state_dbg;
`ifdef TAP_SATURATE_EN
    logic       tap_limit;
`endif

    int n_vec = 0;
    int n_err = 0;

    // clock / reset
    always #5 clk = ~clk;

    cdr_tap_step_controller dut (
        .clk        (clk),
        .rst        (rst),
        .vote_valid (vote_valid),
        .early      (early),
        .late       (late),
        .freeze     (freeze),
        .sl         (sl),
        .sr         (sr),
        .tap_idx    (tap_idx),
        .acc_dbg    (acc_dbg),
        .locked     (locked),
`ifdef TAP_SATURATE_EN
        .tap_limit  (tap_limit),
`endif
        .state_dbg  (state_dbg)
    );

    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: integer bookkeeping of the loop rules
    int m_acc, m_tap, m_settle_left, m_lock, m_sum;
    bit m_sl, m_sr, m_lim, m_valid = 0;

    always @(posedge clk) begin
        m_sl  = 0;
        m_sr  = 0;
        m_lim = 0;
        if (rst) begin
            m_acc = 0; m_tap = 0; m_settle_left = 0; m_lock = 0;
            m_valid = 1;
        end else if (m_settle_left > 0) begin
            m_settle_left = m_settle_left - 1;
        end else if (!freeze) begin
            m_sum = m_acc + (vote_valid ? (int'(early) - int'(late)) : 0);
            if (m_lock < LCYC) m_lock = m_lock + 1;
            if (m_sum >= TH || m_sum <= -TH) begin
                m_acc = 0;
`ifdef TAP_SATURATE_EN
                if ((m_sum > 0 && m_tap == NT - 1) || (m_sum < 0 && m_tap == 0)) begin
                    m_lim = 1;
                end else
`endif
                begin
                    m_lock = 0;
                    m_settle_left = SCYC;
                    if (m_sum > 0) begin
                        m_sl = 1; m_tap = (m_tap + 1) % NT;
                    end else begin
                        m_sr = 1; m_tap = (m_tap + NT - 1) % NT;
                    end
                end
            end else begin
                m_acc = m_sum;
            end
        end
    end

    // Scoreboard compare on every falling edge once the model is seeded
    always @(negedge clk) begin
        if (m_valid) begin
            chk("sl", int'(sl), int'(m_sl));
            chk("sr", int'(sr), int'(m_sr));
            chk("tap_idx", int'(tap_idx), m_tap);
            chk("acc", int'($signed(acc_dbg)), m_acc);
            chk("locked", int'(locked), int'(m_lock == LCYC));
            chk("state", int'(state_dbg), (m_settle_left > 0) ? int'(SETTLE) : int'(ACC));
            if (sl && sr) chk("sl_sr_excl", 1, 0);
`ifdef TAP_SATURATE_EN
            chk("tap_limit", int'(tap_limit), int'(m_lim));
`endif
        end
    end

    // driver: hold inputs for n rising edges, return 1 time unit after the last
    task automatic drive(input bit v, input bit e, input bit l, input bit f, input int n);
        vote_valid = v; early = e; late = l; freeze = f;
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        // reset state
        drive(0, 0, 0, 0, 2);
        chk("lit_rst_sl", int'(sl), 0);
        chk("lit_rst_tap", int'(tap_idx), 0);
        chk("lit_rst_acc", int'(acc_dbg), 0);
        chk("lit_rst_locked", int'(locked), 0);
        chk("lit_rst_state", int'(state_dbg), int'(ACC));
        rst = 1'b0;

        // 8 early votes -> sl one cycle after the 8th
        drive(1, 1, 0, 0, 7);
        chk("lit_acc7", int'(acc_dbg), 7);
        chk("lit_no_sl", int'(sl), 0);
        drive(1, 1, 0, 0, 1);
        chk("lit_sl1", int'(sl), 1);
        chk("lit_tap1", int'(tap_idx), 1);
        chk("lit_acc0", int'(acc_dbg), 0);

        // continuous early: next sl 4+8 cycles after the first pulse
        drive(1, 1, 0, 0, 11);
        chk("lit_settle_sl0", int'(sl), 0);
        chk("lit_settle_acc7", int'(acc_dbg), 7);
        drive(1, 1, 0, 0, 1);
        chk("lit_sl2", int'(sl), 1);
        chk("lit_tap2", int'(tap_idx), 2);

        // freeze holds acc at 5; three more votes after release step
        drive(0, 0, 0, 0, 4);
        drive(1, 1, 0, 0, 5);
        chk("lit_frz_acc5", int'(acc_dbg), 5);
        drive(1, 1, 0, 1, 10);
        chk("lit_frz_hold", int'(acc_dbg), 5);
        chk("lit_frz_tap", int'(tap_idx), 2);
        drive(1, 1, 0, 0, 3);
        chk("lit_frz_sl", int'(sl), 1);
        chk("lit_frz_tap3", int'(tap_idx), 3);

        // reset during the pulse cycle
        drive(0, 0, 0, 0, 4);
        drive(1, 1, 0, 0, 8);
        chk("lit_pre_rst_sl", int'(sl), 1);
        rst = 1'b1;
        drive(1, 1, 0, 0, 1);
        rst = 1'b0;
        chk("lit_mid_rst_sl", int'(sl), 0);
        chk("lit_mid_rst_tap", int'(tap_idx), 0);
        chk("lit_mid_rst_state", int'(state_dbg), int'(ACC));
        drive(1, 1, 0, 0, 1);
        chk("lit_first_vote", int'(acc_dbg), 1);

        // alternation then 8 late: sr wraps 0 -> 15 (or saturates)
        drive(1, 0, 1, 0, 1);
        for (int i = 0; i < 50; i++) begin
            drive(1, 1, 0, 0, 1);
            drive(1, 0, 1, 0, 1);
        end
        chk("lit_alt_acc", int'(acc_dbg), 0);
        drive(1, 0, 1, 0, 7);
        chk("lit_acc_m7", int'($signed(acc_dbg)), -7);
        drive(1, 0, 1, 0, 1);
`ifdef TAP_SATURATE_EN
        chk("lit_sat_sr", int'(sr), 0);
        chk("lit_sat_limit", int'(tap_limit), 1);
        chk("lit_sat_tap", int'(tap_idx), 0);
`else
        chk("lit_wrap_sr", int'(sr), 1);
        chk("lit_wrap_tap", int'(tap_idx), 15);
`endif

        // early=late cancels; lock after 256 ACC cycles from reset
        rst = 1'b1;
        drive(0, 0, 0, 0, 1);
        rst = 1'b0;
        drive(1, 1, 1, 0, 20);
        chk("lit_tie_acc", int'(acc_dbg), 0);
        drive(0, 0, 0, 0, 235);
        chk("lit_lock_255", int'(locked), 0);
        drive(0, 0, 0, 0, 1);
        chk("lit_lock_256", int'(locked), 1);
        drive(1, 1, 0, 1, 5);
        chk("lit_lock_frz", int'(locked), 1);
        drive(1, 1, 0, 0, 8);
        chk("lit_lock_clr", int'(locked), 0);
        chk("lit_lock_sl", int'(sl), 1);

        drive(0, 0, 0, 0, 6);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
